// File: rtl/bram_port_arbiter_if.sv
// Request/response bundle between the two RAM clients and bram_port_arbiter.
// Port 1 occupies the high half of every packed per-port field.
interface bram_port_arbiter_if #(
    parameter int ADDR_W    = 10,
    parameter int RAM_WIDTH = 18
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_we;
    logic [2*ADDR_W-1:0]    req_addr;
    logic [2*RAM_WIDTH-1:0] req_wdata;
    logic [1:0]             rsp_valid;
    logic [RAM_WIDTH-1:0]   rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin two-port front end for one single-port read-first block RAM;
// a tag pipeline follows the RAM read latency and routes read data back.
module bram_port_arbiter #(
    parameter int RAM_WIDTH    = 18,
    parameter int RAM_DEPTH    = 1024,
    parameter int READ_LATENCY = 2,
    localparam int ADDR_W      = $clog2(RAM_DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    bram_port_arbiter_if.slave   bus,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [RAM_WIDTH-1:0] ram_din,
    output logic                 ram_we,
    output logic                 ram_en,
    output logic                 ram_rst,
    output logic                 ram_regce,
    input  logic [RAM_WIDTH-1:0] ram_dout
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_cfg_err
        $error("bram_port_arbiter: READ_LATENCY must be 1 or 2");
    end

    logic                    last_grant_q;
    logic                    grant_any;
    logic                    grant_sel;
    logic                    grant_we;
    logic [READ_LATENCY-1:0] vld_p;
    logic [READ_LATENCY-1:0] port_p;

    // Arbitration: the port that did not win last time wins a contention.
    // grant_sel stays 0 without a grant so the RAM sees port-0 values.
    always_comb begin
        grant_any = (|bus.req_valid) && !rst_in;
        grant_sel = 1'b0;
        if (grant_any) begin
            if (&bus.req_valid) grant_sel = ~last_grant_q;
            else                grant_sel = bus.req_valid[1];
        end
        grant_we = grant_sel ? bus.req_we[1] : bus.req_we[0];
    end

    always_comb begin
        bus.req_ready = 2'b00;
        if (grant_any) bus.req_ready = grant_sel ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)         last_grant_q <= 1'b1;
        else if (grant_any) last_grant_q <= grant_sel;
    end

    // RAM port drive, combinational from the granted request
    assign ram_en    = grant_any;
    assign ram_we    = grant_any && grant_we;
    assign ram_addr  = grant_sel ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                                 : bus.req_addr[ADDR_W-1:0];
    assign ram_din   = grant_sel ? bus.req_wdata[2*RAM_WIDTH-1:RAM_WIDTH]
                                 : bus.req_wdata[RAM_WIDTH-1:0];
    assign ram_rst   = rst_in;
    assign ram_regce = 1'b1;

    // Stage p0 captures the issued read; stage p(READ_LATENCY-1) lines up with ram_dout.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= grant_any && !grant_we;
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        port_p[0] <= grant_sel;
        for (int i = 1; i < READ_LATENCY; i++) port_p[i] <= port_p[i-1];
    end

    // Response stage: shared data, per-port strobe
    assign bus.rsp_valid = {vld_p[READ_LATENCY-1] &  port_p[READ_LATENCY-1],
                            vld_p[READ_LATENCY-1] & ~port_p[READ_LATENCY-1]};
    assign bus.rsp_data  = ram_dout;

endmodule
